// File: rtl/mmio_bus_ctrl.sv
// Data-port memory-map controller: address decode, single-transaction sequencing, GPIO output register.
// Optional build macro MMIO_TIMEOUT_EN adds an ACCESS wait timeout with a sticky bus error flag.
module mmio_bus_ctrl #(
  parameter int unsigned                  NUM_REGIONS    = 4,
  parameter logic [NUM_REGIONS*32-1:0]    REGION_BASE    = {32'h3000, 32'h800, 32'h400, 32'h0},
  parameter logic [NUM_REGIONS*32-1:0]    REGION_MASK    = {32'hF000, 32'hFC00, 32'hFC00, 32'hFC00},
  parameter logic [31:0]                  GPIO_BASE      = 32'h0000_4000,
  parameter int unsigned                  GPIO_WIDTH     = 8,
  parameter int unsigned                  TIMEOUT_CYCLES = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_loadReq,
  input  logic                      i_storeReq,
  input  logic [31:0]               i_dataAddr,
  input  logic [31:0]               i_dataOut,
  output logic [31:0]               o_dataIn,
  output logic                      o_memValid,
  output logic [NUM_REGIONS-1:0]    o_sel,
  output logic                      o_we,
  output logic [31:0]               o_addr,
  output logic [31:0]               o_wdata,
  input  logic [NUM_REGIONS*32-1:0] i_rdata,
  input  logic [NUM_REGIONS-1:0]    i_ack,
  output logic [GPIO_WIDTH-1:0]     o_gpio,
  output logic                      o_busErr
);

  localparam int unsigned IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_e;
  typedef enum logic [1:0] {T_NONE, T_EXT, T_GPIO} tgt_e;

  state_e                 state_q;
  tgt_e                   tgt_q;
  logic [IDX_W-1:0]       idx_q;
  logic [NUM_REGIONS-1:0] sel_q;
  logic                   we_q;
  logic                   mem_valid_q;
  logic [31:0]            addr_q;
  logic [31:0]            wdata_q;
  logic [31:0]            data_in_q;
  logic [GPIO_WIDTH-1:0]  gpio_q;

  logic                   gpio_hit_c;
  logic                   dec_hit_c;
  logic [IDX_W-1:0]       dec_idx_c;
  logic                   ack_sel_c;
  logic [31:0]            rdata_sel_c;
  logic [GPIO_WIDTH-1:0]  gpio_upd_c;
  logic [GPIO_WIDTH-1:0]  wd_c;

  // Region decode: descending scan so the lowest-index hit is the one left standing
  always_comb begin
    dec_hit_c = 1'b0;
    dec_idx_c = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if ((i_dataAddr & REGION_MASK[32*i +: 32]) == REGION_BASE[32*i +: 32]) begin
        dec_hit_c = 1'b1;
        dec_idx_c = IDX_W'(i);
      end
    end
  end

  assign gpio_hit_c  = (i_dataAddr[31:4] == GPIO_BASE[31:4]);
  assign ack_sel_c   = i_ack[idx_q];
  assign rdata_sel_c = i_rdata[32*idx_q +: 32];
  assign wd_c        = wdata_q[GPIO_WIDTH-1:0];

  // GPIO register views selected by word offset within the block
  always_comb begin
    gpio_upd_c = gpio_q;
    case (addr_q[3:2])
      2'd0:    gpio_upd_c = wd_c;
      2'd1:    gpio_upd_c = gpio_q | wd_c;
      2'd2:    gpio_upd_c = gpio_q & ~wd_c;
      default: gpio_upd_c = gpio_q ^ wd_c;
    endcase
  end

`ifdef MMIO_TIMEOUT_EN
  logic [7:0] cnt_q;
  logic       bus_err_q;
  assign o_busErr = bus_err_q;
`else
  logic unused_timeout_c;
  assign unused_timeout_c = (TIMEOUT_CYCLES == 0);
  assign o_busErr = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      tgt_q       <= T_NONE;
      idx_q       <= '0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      mem_valid_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      data_in_q   <= '0;
      gpio_q      <= '0;
`ifdef MMIO_TIMEOUT_EN
      cnt_q       <= '0;
      bus_err_q   <= 1'b0;
`endif
    end else begin
      mem_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_loadReq || i_storeReq) begin
            addr_q  <= i_dataAddr;
            wdata_q <= i_dataOut;
            we_q    <= i_storeReq;
            state_q <= S_ACCESS;
`ifdef MMIO_TIMEOUT_EN
            cnt_q   <= '0;
`endif
            if (gpio_hit_c) begin
              tgt_q <= T_GPIO;
            end else if (dec_hit_c) begin
              tgt_q <= T_EXT;
              idx_q <= dec_idx_c;
              sel_q <= NUM_REGIONS'(1) << dec_idx_c;
            end else begin
              tgt_q <= T_NONE;
            end
          end
        end
        S_ACCESS: begin
          case (tgt_q)
            T_GPIO: begin
              if (we_q) gpio_q <= gpio_upd_c;
              data_in_q   <= we_q ? 32'h0 : 32'(gpio_q);
              mem_valid_q <= 1'b1;
              state_q     <= S_RESP;
            end
            T_EXT: begin
              // Ack beats a coincident timeout
              if (ack_sel_c) begin
                sel_q       <= '0;
                data_in_q   <= we_q ? 32'h0 : rdata_sel_c;
                mem_valid_q <= 1'b1;
                state_q     <= S_RESP;
              end
`ifdef MMIO_TIMEOUT_EN
              else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
                sel_q       <= '0;
                bus_err_q   <= 1'b1;
                data_in_q   <= 32'hDEAD_BEEF;
                mem_valid_q <= 1'b1;
                state_q     <= S_RESP;
              end else begin
                cnt_q <= cnt_q + 8'd1;
              end
`endif
            end
            default: begin
              data_in_q   <= 32'h0;
              mem_valid_q <= 1'b1;
              state_q     <= S_RESP;
            end
          endcase
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_dataIn   = data_in_q;
  assign o_memValid = mem_valid_q;
  assign o_sel      = sel_q;
  assign o_we       = we_q;
  assign o_addr     = addr_q;
  assign o_wdata    = wdata_q;
  assign o_gpio     = gpio_q;

endmodule
